// File: rtl/sn74hc165_2x_keys.sv
// Keyboard scanner for two cascaded SN74HC165 shift registers (16 keys).
// Loads and shifts in the key lines, then debounces them and latches sticky press events.
module sn74hc165_2x_keys #(
    parameter int N_BITS    = 16,
    parameter int SCLK_DIV  = 36,
    parameter int LOAD_CLKS = 4,
    parameter int GAP_CLKS  = 8,
    parameter int FILTER    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              load_n,
    output logic              sclk,
    input  logic              sdi,
    output logic [N_BITS-1:0] level,
    output logic [N_BITS-1:0] keys,
    output logic [N_BITS-1:0] keys_down,
    input  logic              clear_req,
    input  logic [N_BITS-1:0] clear_mask,
    output logic              frame_done
);

    localparam int TMAX12 = (LOAD_CLKS > SCLK_DIV) ? LOAD_CLKS : SCLK_DIV;
    localparam int TMAX   = (TMAX12 > GAP_CLKS) ? TMAX12 : GAP_CLKS;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int BW     = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int CW     = $clog2(FILTER) + 1;

    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_UPDATE, S_GAP} state_t;

    state_t            r_state;
    logic [TW-1:0]     r_tmr;
    logic [BW-1:0]     r_bit;
    logic [N_BITS-1:0] r_shift;
    logic              r_load_n;
    logic              r_sclk;
    logic [N_BITS-1:0] r_level;
    logic [N_BITS-1:0] r_keys;
    logic [N_BITS-1:0] r_keys_down;
    logic              r_frame_done;
    logic [CW-1:0]     r_cnt [N_BITS];

    logic [N_BITS-1:0] w_keys_next;
    logic [N_BITS-1:0] w_rise;
    logic [N_BITS-1:0] w_clr;
    logic [CW-1:0]     w_cnt_next [N_BITS];

    // Debounce: a bit toggles only after FILTER consecutive differing frames.
    always_comb begin
        w_keys_next = r_keys;
        for (int unsigned b = 0; b < N_BITS; b++) begin
            w_cnt_next[b] = r_cnt[b];
            if (r_state == S_UPDATE) begin
                if (r_shift[b] != r_keys[b]) begin
                    if (r_cnt[b] == CW'(FILTER - 1)) begin
                        w_keys_next[b] = ~r_keys[b];
                        w_cnt_next[b]  = '0;
                    end else begin
                        w_cnt_next[b] = r_cnt[b] + 1'b1;
                    end
                end else begin
                    w_cnt_next[b] = '0;
                end
            end
        end
        w_rise = w_keys_next & ~r_keys;
        w_clr  = clear_req ? clear_mask : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_LOAD;
            r_tmr        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_load_n     <= 1'b1;
            r_sclk       <= 1'b0;
            r_level      <= '0;
            r_keys       <= '0;
            r_keys_down  <= '0;
            r_frame_done <= 1'b0;
            for (int unsigned b = 0; b < N_BITS; b++) r_cnt[b] <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_keys       <= w_keys_next;
            r_cnt        <= w_cnt_next;
            // A rise in the same cycle as a clear wins, so no press is lost.
            r_keys_down  <= (r_keys_down & ~w_clr) | w_rise;
            case (r_state)
                S_LOAD: begin
                    if (r_tmr == TW'(LOAD_CLKS)) begin
                        r_load_n <= 1'b1;
                        r_tmr    <= '0;
                        r_state  <= S_SHIFT;
                    end else begin
                        r_load_n <= 1'b0;
                        r_tmr    <= r_tmr + 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_tmr <= r_tmr + 1'b1;
                    if (r_tmr == TW'(SCLK_DIV - 1)) begin
                        r_tmr <= '0;
                        if (!r_sclk) begin
                            r_shift <= {r_shift[N_BITS-2:0], sdi};
                            r_sclk  <= 1'b1;
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit == BW'(N_BITS - 1)) begin
                                r_bit   <= '0;
                                r_state <= S_UPDATE;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end
                    end
                end
                S_UPDATE: begin
                    r_level      <= r_shift;
                    r_frame_done <= 1'b1;
                    r_tmr        <= '0;
                    r_state      <= S_GAP;
                end
                default: begin
                    if (r_tmr == TW'(GAP_CLKS - 1)) begin
                        r_tmr   <= '0;
                        r_state <= S_LOAD;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
            endcase
        end
    end

    assign load_n     = r_load_n;
    assign sclk       = r_sclk;
    assign level      = r_level;
    assign keys       = r_keys;
    assign keys_down  = r_keys_down;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sn74hc165_2x_keys.sv
// Directed bench for sn74hc165_2x_keys with a behavioural model of the two cascaded '165s.
`timescale 1ns/1ps
module tb_sn74hc165_2x_keys;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_n, sclk, sdi, frame_done;
    logic [15:0] level, keys, keys_down;
    logic        clear_req = 1'b0;
    logic [15:0] clear_mask = '0;
    logic [15:0] kb = '0;

    logic [15:0] sr = '0;
    logic        sclk_q = 1'b0;
    int          n_asserts = 0;
    int          n_fail = 0;
    int          viol = 0;

    always #7 clk = ~clk;

    sn74hc165_2x_keys dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_n     (load_n),
        .sclk       (sclk),
        .sdi        (sdi),
        .level      (level),
        .keys       (keys),
        .keys_down  (keys_down),
        .clear_req  (clear_req),
        .clear_mask (clear_mask),
        .frame_done (frame_done)
    );

    // '165 chain: parallel load while load_n low, shift toward QH on sclk rise.
    always @(posedge clk) begin
        sclk_q <= sclk;
        if (load_n === 1'b0)
            sr <= kb;
        else if (sclk === 1'b1 && sclk_q === 1'b0)
            sr <= {sr[14:0], 1'b0};
    end
    assign sdi = sr[15];

    always @(negedge clk)
        if (load_n === 1'b0 && sclk !== 1'b0) viol++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < n * 2000) begin
            @(negedge clk);
            cyc++;
            if (frame_done === 1'b1) got++;
        end
        chk("frame_wait", got, n);
    endtask

    initial begin
        int to, w, npulse, cyc, last_rise, pmin, pmax, falls;
        logic prev;

        // Reset
        repeat (5) @(negedge clk);
        chk("rst_load_n", load_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_level", level, 16'h0000);
        chk("rst_keys", keys, 16'h0000);
        chk("rst_keys_down", keys_down, 16'h0000);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;

        // Frame timing
        to = 0;
        while (load_n !== 1'b0 && to < 3000) begin @(negedge clk); to++; end
        chk("load_wait_timeout", (to < 3000), 1);
        w = 0;
        while (load_n === 1'b0 && w < 100) begin @(negedge clk); w++; end
        chk("load_n_width", w, 4);
        npulse = 0; cyc = 0; last_rise = -1; pmin = 9999; pmax = 0; prev = sclk;
        while (frame_done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (sclk === 1'b1 && prev === 1'b0) begin
                npulse++;
                if (last_rise >= 0) begin
                    if (cyc - last_rise < pmin) pmin = cyc - last_rise;
                    if (cyc - last_rise > pmax) pmax = cyc - last_rise;
                end
                last_rise = cyc;
            end
            prev = sclk;
        end
        chk("sclk_pulses", npulse, 16);
        chk("sclk_period_min", pmin, 72);
        chk("sclk_period_max", pmax, 72);

        // Press
        repeat (700) @(negedge clk);
        wait_frames(1);
        kb = 16'h8231;
        wait_frames(1);
        chk("press_level_early", level, 16'h8231);
        chk("press_keys_early", keys, 16'h0000);
        wait_frames(9);
        chk("press_level", level, 16'h8231);
        chk("press_keys", keys, 16'h8231);
        chk("press_keys_down", keys_down, 16'h8231);

        // Release
        kb = 16'h0000;
        wait_frames(10);
        chk("rel_level", level, 16'h0000);
        chk("rel_keys", keys, 16'h0000);
        chk("rel_keys_down", keys_down, 16'h8231);

        // Clear with empty mask, then real clear
        clear_req = 1'b1; clear_mask = 16'h0000;
        @(negedge clk);
        clear_req = 1'b0;
        @(negedge clk);
        chk("clr0_keys_down", keys_down, 16'h8231);
        clear_req = 1'b1; clear_mask = 16'h8231;
        @(negedge clk);
        clear_req = 1'b0; clear_mask = 16'h0000;
        @(negedge clk);
        chk("clr_keys_down", keys_down, 16'h0000);
        chk("clr_level", level, 16'h0000);
        chk("clr_keys", keys, 16'h0000);

        // Glitch: two frames only
        wait_frames(1);
        kb = 16'h0001;
        wait_frames(1);
        chk("glitch_level", level, 16'h0001);
        chk("glitch_keys", keys, 16'h0000);
        wait_frames(1);
        kb = 16'h0000;
        wait_frames(1);
        chk("glitch_level_after", level, 16'h0000);
        chk("glitch_keys_after", keys, 16'h0000);
        chk("glitch_keys_down", keys_down, 16'h0000);

        // Race: clear strobe in the UPDATE cycle where keys[2] rises
        kb = 16'h0004;
        wait_frames(7);
        chk("race_keys_pre", keys, 16'h0000);
        falls = 0; cyc = 0; prev = sclk;
        while (falls < 16 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev === 1'b1 && sclk === 1'b0) falls++;
            prev = sclk;
        end
        chk("race_sclk_falls", falls, 16);
        clear_req = 1'b1; clear_mask = 16'h0004;
        @(negedge clk);
        clear_req = 1'b0; clear_mask = 16'h0000;
        chk("race_frame_done", frame_done, 1);
        chk("race_keys", keys, 16'h0004);
        chk("race_keys_down", keys_down, 16'h0004);

        // Mid-frame reset
        to = 0;
        while (sclk !== 1'b1 && to < 3000) begin @(negedge clk); to++; end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_load_n", load_n, 1);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_level", level, 16'h0000);
        chk("mid_rst_keys", keys, 16'h0000);
        chk("mid_rst_keys_down", keys_down, 16'h0000);
        wait_frames(1);
        chk("post_rst_level", level, 16'h0004);
        chk("post_rst_keys", keys, 16'h0000);

        chk("sclk_low_during_load", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/sn74hc165_2x_keys.md
Name: sn74hc165_2x_keys

Overview:
- Synthesizable keyboard scanner for two cascaded SN74HC165 parallel-in/serial-out registers (16 keys).
- Periodically loads and shifts in the 16 key lines.
- Debounces each key and latches sticky "key pressed" events.
- Sits between the keyboard connector pins and the bus register file. The FMC bus reads level/keys/keys_down and issues clear requests.

Parameters:
- N_BITS, 16, number of serial bits per frame (two cascaded '165s).
- SCLK_DIV, 36, clk cycles per sclk half-period (72 MHz clk -> 1 MHz sclk).
- LOAD_CLKS, 4, clk cycles load_n is held low per frame.
- GAP_CLKS, 8, idle clk cycles between frames.
- FILTER, 8, consecutive identical frames required to change a debounced bit.

Ports:
- clk, in, 1, system clock (72 MHz).
- rst_n, in, 1, reset.
- load_n, out, 1, '165 SH/LD_n; low = parallel load.
- sclk, out, 1, '165 shift clock; idle low.
- sdi, in, 1, serial data from QH of the last '165.
- level, out, N_BITS, raw key vector from the last completed frame.
- keys, out, N_BITS, debounced key vector.
- keys_down, out, N_BITS, sticky per-bit press flags (0->1 transitions of keys).
- clear_req, in, 1, one-cycle strobe to clear keys_down bits.
- clear_mask, in, N_BITS, bits of keys_down to clear when clear_req=1.
- frame_done, out, 1, one-cycle pulse when level is updated.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low: rst_n sampled on rising clk; rst_n=0 resets all state.
- Reset values:
  - load_n=1, sclk=0, frame_done=0.
  - level=0, keys=0, keys_down=0.
  - All filter counters 0; FSM in LOAD.
- Key polarity: active-high; sdi bit value is the key state, no inversion.
- FSM states LOAD -> SHIFT -> UPDATE -> GAP -> LOAD.
- LOAD:
  - load_n=0, sclk=0 for LOAD_CLKS cycles.
  - load_n then goes 1 and the FSM enters SHIFT.
- SHIFT (load_n=1), repeated for bit index i=0..N_BITS-1:
  - sclk low phase of SCLK_DIV cycles. On its last cycle, sdi is sampled into the shift register.
  - MSB-first: the first sampled bit becomes bit N_BITS-1 (keyboard input 15); the last sampled becomes bit 0.
  - sclk high phase of SCLK_DIV cycles. The rising sclk edge advances the '165 chain.
  - After bit N_BITS-1 is sampled, sclk drops back to 0 and the FSM enters UPDATE; no extra high phase is required.
- Frame period:
  - LOAD_CLKS + 2*SCLK_DIV*N_BITS + 1 + GAP_CLKS clk cycles (1165 clocks, ~16.2 us at default).
  - Exact equality is not required; the bench checks only the load_n width and the sclk period.
- UPDATE (one cycle):
  - level <= shift register; frame_done=1.
  - Filter, per bit b:
    - If level_new[b] != keys[b], cnt[b]++; otherwise cnt[b]=0.
    - When cnt[b] reaches FILTER-1 and the new sample still differs, keys[b] toggles and cnt[b]=0.
    - Net effect: a change must persist for FILTER consecutive frames (~130 us default).
- Counter width: clog2(FILTER)+1; the counter never wraps.
- keys_down:
  - keys_down[b] is set in the cycle keys[b] goes 0->1.
  - Stays set after the key is released.
  - Clear: keys_down <= (keys_down & ~clear_mask) | rise. clear_req and a new rise on the same bit in the same cycle leaves the bit SET (no lost event).
  - clear_req with clear_mask=0 has no effect.
- Key release (keys 1->0) never affects keys_down.
- clear_req does not affect level, keys, the scan FSM or the filter counters.
- Reset mid-frame: in the next cycle load_n=1, sclk=0 and all outputs are 0. Scanning restarts from LOAD with no partial frame committed.
- Outputs are registered; no combinational path from sdi or clear_req to any output.

Test Plan:
- Reset: hold rst_n=0 for 5 clk -> load_n=1, sclk=0, level=keys=keys_down=0x0000.
- Frame timing: with kb=0x0000 -> load_n low for exactly 4 clk per frame; 16 sclk pulses per frame with 72-clk period; sclk=0 whenever load_n=0.
- Press: kb=0x0000 for 10 us, then kb=0x8231 for 400 us -> level=0x8231, keys=0x8231, keys_down=0x8231.
- Release: kb=0x0000 for 400 us -> level=0x0000, keys=0x0000, keys_down=0x8231 (sticky).
- Clear: clear_req pulse with clear_mask=0x8231 -> keys_down=0x0000; level=0x0000 and keys=0x0000 unchanged.
- Glitch and race:
  - kb=0x0001 for 2 frames, then 0x0000 -> level briefly 0x0001; keys and keys_down stay 0x0000.
  - Hold kb=0x0004 and pulse clear_req (mask 0x0004) in the cycle keys[2] rises -> keys_down[2]=1.
